// File: rtl/evict_wb_rx.sv
// -----------------------------------------------------------------------------
// evict_wb_rx
//   Receives the evicted-line beat stream from the evict data buffer and turns
//   each line into one memory write burst (AW + W). Every burst holds a slot
//   until its write response returns; the response retires the slot and emits
//   a one-cycle completion carrying the line's rob_entry_id and txnid.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   ev_vld/ev_rdy         evict beat handshake
//   ev_data, ev_last      beat payload and end-of-line marker
//   ev_addr, ev_txnid,
//   ev_rob_id             line attributes, taken from the first beat only
//   aw_vld/aw_rdy         write-address handshake
//   aw_addr, aw_id,
//   aw_len                burst address, slot index, beats-1
//   w_vld/w_rdy           write-data handshake
//   w_data, w_last        beat data, producer's end-of-line marker
//   b_vld, b_id           write response (always accepted)
//   wb_done_*             completion pulse with rob_entry_id / txnid
//   err_sticky            [0] beat-count error, [1] response to a free slot
// -----------------------------------------------------------------------------
module evict_wb_rx #(
   parameter int  DATA_WIDTH     = 1024,
   parameter int  ADDR_WIDTH     = 40,
   parameter int  TXNID_WIDTH    = 8,
   parameter int  ROB_ID_WIDTH   = 6,
   parameter int  BEATS_PER_LINE = 4,
   parameter int  OT_NUM         = 8,
   parameter int  WFIFO_DEPTH    = 8,
   localparam int ID_W           = $clog2(OT_NUM)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ev_vld,
   output logic                    ev_rdy,
   input  logic [DATA_WIDTH-1:0]   ev_data,
   input  logic [ADDR_WIDTH-1:0]   ev_addr,
   input  logic [TXNID_WIDTH-1:0]  ev_txnid,
   input  logic [ROB_ID_WIDTH-1:0] ev_rob_id,
   input  logic                    ev_last,
   output logic                    aw_vld,
   input  logic                    aw_rdy,
   output logic [ADDR_WIDTH-1:0]   aw_addr,
   output logic [ID_W-1:0]         aw_id,
   output logic [7:0]              aw_len,
   output logic                    w_vld,
   input  logic                    w_rdy,
   output logic [DATA_WIDTH-1:0]   w_data,
   output logic                    w_last,
   input  logic                    b_vld,
   input  logic [ID_W-1:0]         b_id,
   output logic                    wb_done_vld,
   output logic [ROB_ID_WIDTH-1:0] wb_done_rob_id,
   output logic [TXNID_WIDTH-1:0]  wb_done_txnid,
   output logic [1:0]              err_sticky
);

   localparam int               WP_W      = $clog2(WFIFO_DEPTH);
   localparam int               CNT_W     = (BEATS_PER_LINE > 1) ? $clog2(BEATS_PER_LINE) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_LINE - 1);
   localparam logic [7:0]       AW_LEN    = 8'(BEATS_PER_LINE - 1);

   typedef enum logic {IDLE = 1'b0, IN_LINE = 1'b1} state_e;

   typedef struct packed {
      logic [ROB_ID_WIDTH-1:0] rob_id;
      logic [TXNID_WIDTH-1:0]  txnid;
   } slot_meta_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [ID_W-1:0]       id;
   } aw_entry_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  last;
   } w_entry_t;

   // ---------------------------------------------------------------- state
   state_e               state_q, state_d;
   logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic [OT_NUM-1:0]    busy_q, busy_d;
   logic [1:0]           err_q, err_d;
   logic                 done_vld_q, done_vld_d;
   slot_meta_t           done_meta_q, done_meta_d;
   logic                 ready_en_q;
   logic [ID_W:0]        awq_wr_ptr_q, awq_wr_ptr_d, awq_rd_ptr_q, awq_rd_ptr_d;
   logic [WP_W:0]        wf_wr_ptr_q, wf_wr_ptr_d, wf_rd_ptr_q, wf_rd_ptr_d;

   slot_meta_t           slot_meta_q [OT_NUM];
   aw_entry_t            awq_mem_q   [OT_NUM];
   w_entry_t             wf_mem_q    [WFIFO_DEPTH];

   // ---------------------------------------------------------------- status
   logic                 free_exists;
   logic [ID_W-1:0]      free_slot;
   logic                 awq_full, wf_full;
   logic                 ev_acc, first_acc, aw_pop, w_pop;
   aw_entry_t            aw_head;
   w_entry_t             w_head;

   // Descending scan so the lowest-index free slot is the one left standing.
   // Only busy_q is consulted: a slot released this cycle is not reusable yet.
   always_comb begin
      free_exists = 1'b0;
      free_slot   = '0;
      for (int i = OT_NUM - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            free_exists = 1'b1;
            free_slot   = ID_W'(i);
         end
      end
   end

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign awq_full = (awq_wr_ptr_q[ID_W] != awq_rd_ptr_q[ID_W]) &&
                     (awq_wr_ptr_q[ID_W-1:0] == awq_rd_ptr_q[ID_W-1:0]);
   assign wf_full  = (wf_wr_ptr_q[WP_W] != wf_rd_ptr_q[WP_W]) &&
                     (wf_wr_ptr_q[WP_W-1:0] == wf_rd_ptr_q[WP_W-1:0]);

   // A line already in progress owns its slot and AW entry; only a new line
   // needs a free slot and AW room. ready_en_q holds ev_rdy low through reset.
   assign ev_rdy    = ready_en_q && !wf_full &&
                      ((state_q == IN_LINE) || (free_exists && !awq_full));
   assign ev_acc    = ev_vld && ev_rdy;
   assign first_acc = ev_acc && (state_q == IDLE);

   // ---------------------------------------------------------------- outputs
   assign aw_head = awq_mem_q[awq_rd_ptr_q[ID_W-1:0]];
   assign w_head  = wf_mem_q[wf_rd_ptr_q[WP_W-1:0]];

   assign aw_vld  = (awq_wr_ptr_q != awq_rd_ptr_q);
   assign w_vld   = (wf_wr_ptr_q != wf_rd_ptr_q);
   assign aw_pop  = aw_vld && aw_rdy;
   assign w_pop   = w_vld && w_rdy;

   // Payloads are forced to zero while invalid so unwritten storage never
   // leaks onto the bus (and outputs read 0 out of reset).
   assign aw_addr = aw_vld ? aw_head.addr : '0;
   assign aw_id   = aw_vld ? aw_head.id   : '0;
   assign aw_len  = aw_vld ? AW_LEN       : '0;
   assign w_data  = w_vld  ? w_head.data  : '0;
   assign w_last  = w_vld  ? w_head.last  : 1'b0;

   assign wb_done_vld    = done_vld_q;
   assign wb_done_rob_id = done_meta_q.rob_id;
   assign wb_done_txnid  = done_meta_q.txnid;
   assign err_sticky     = err_q;

   // ---------------------------------------------------------------- next state
   // NOTE: every variable gets a default at the top of the block; a path that
   // leaves one unassigned would otherwise infer a latch.
   always_comb begin
      state_d      = state_q;
      beat_cnt_d   = beat_cnt_q;
      busy_d       = busy_q;
      err_d        = err_q;
      done_vld_d   = 1'b0;
      done_meta_d  = '0;
      awq_wr_ptr_d = first_acc ? awq_wr_ptr_q + (ID_W+1)'(1) : awq_wr_ptr_q;
      awq_rd_ptr_d = aw_pop    ? awq_rd_ptr_q + (ID_W+1)'(1) : awq_rd_ptr_q;
      wf_wr_ptr_d  = ev_acc    ? wf_wr_ptr_q  + (WP_W+1)'(1) : wf_wr_ptr_q;
      wf_rd_ptr_d  = w_pop     ? wf_rd_ptr_q  + (WP_W+1)'(1) : wf_rd_ptr_q;

      // Line framing follows ev_last only; a wrong beat count is flagged but
      // never truncates or extends the burst.
      if (ev_acc) begin
         if (ev_last) begin
            if (beat_cnt_q != LAST_BEAT) err_d[0] = 1'b1;
            state_d    = IDLE;
            beat_cnt_d = '0;
         end else begin
            if (beat_cnt_q == LAST_BEAT) err_d[0] = 1'b1;
            else                         beat_cnt_d = beat_cnt_q + CNT_W'(1);
            state_d = IN_LINE;
         end
      end

      if (first_acc) busy_d[free_slot] = 1'b1;

      // Allocation targets a slot free in busy_q and release a slot busy in
      // busy_q, so the two updates never touch the same bit.
      if (b_vld) begin
         if (busy_q[b_id]) begin
            busy_d[b_id] = 1'b0;
            done_vld_d   = 1'b1;
            done_meta_d  = slot_meta_q[b_id];
         end else begin
            err_d[1] = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- registers
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         beat_cnt_q   <= '0;
         busy_q       <= '0;
         err_q        <= '0;
         done_vld_q   <= 1'b0;
         done_meta_q  <= '0;
         ready_en_q   <= 1'b0;
         awq_wr_ptr_q <= '0;
         awq_rd_ptr_q <= '0;
         wf_wr_ptr_q  <= '0;
         wf_rd_ptr_q  <= '0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         done_vld_q   <= done_vld_d;
         done_meta_q  <= done_meta_d;
         ready_en_q   <= 1'b1;
         awq_wr_ptr_q <= awq_wr_ptr_d;
         awq_rd_ptr_q <= awq_rd_ptr_d;
         wf_wr_ptr_q  <= wf_wr_ptr_d;
         wf_rd_ptr_q  <= wf_rd_ptr_d;
      end
   end

   // NOTE: storage arrays are not reset; entries are only read while the
   // matching valid/busy bit says they were written, and the pointers and busy
   // flags above are reset.
   always_ff @(posedge clk) begin
      if (first_acc) begin
         slot_meta_q[free_slot]             <= '{rob_id: ev_rob_id, txnid: ev_txnid};
         awq_mem_q[awq_wr_ptr_q[ID_W-1:0]]  <= '{addr: ev_addr, id: free_slot};
      end
      if (ev_acc) wf_mem_q[wf_wr_ptr_q[WP_W-1:0]] <= '{data: ev_data, last: ev_last};
   end

endmodule

// File: tb/tb_evict_wb_rx.sv
// -----------------------------------------------------------------------------
// tb_evict_wb_rx
//   Directed bench for evict_wb_rx: single line, slot exhaustion, W back-
//   pressure, out-of-order responses, beat-count error, reset mid-line.
//   Inputs change #1 after the rising edge; outputs are logged on the falling
//   edge whenever a handshake or completion is present.
// -----------------------------------------------------------------------------
module tb_evict_wb_rx;

   localparam int DW  = 1024;
   localparam int AW  = 40;
   localparam int TW  = 8;
   localparam int RW  = 6;
   localparam int IDW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ev_vld = 1'b0;
   logic          ev_rdy;
   logic [DW-1:0] ev_data = '0;
   logic [AW-1:0] ev_addr = '0;
   logic [TW-1:0] ev_txnid = '0;
   logic [RW-1:0] ev_rob_id = '0;
   logic          ev_last = 1'b0;
   logic          aw_vld;
   logic          aw_rdy = 1'b0;
   logic [AW-1:0] aw_addr;
   logic [IDW-1:0] aw_id;
   logic [7:0]    aw_len;
   logic          w_vld;
   logic          w_rdy = 1'b0;
   logic [DW-1:0] w_data;
   logic          w_last;
   logic          b_vld = 1'b0;
   logic [IDW-1:0] b_id = '0;
   logic          wb_done_vld;
   logic [RW-1:0] wb_done_rob_id;
   logic [TW-1:0] wb_done_txnid;
   logic [1:0]    err_sticky;

   evict_wb_rx dut (
      .clk(clk), .rst(rst),
      .ev_vld(ev_vld), .ev_rdy(ev_rdy), .ev_data(ev_data), .ev_addr(ev_addr),
      .ev_txnid(ev_txnid), .ev_rob_id(ev_rob_id), .ev_last(ev_last),
      .aw_vld(aw_vld), .aw_rdy(aw_rdy), .aw_addr(aw_addr), .aw_id(aw_id), .aw_len(aw_len),
      .w_vld(w_vld), .w_rdy(w_rdy), .w_data(w_data), .w_last(w_last),
      .b_vld(b_vld), .b_id(b_id),
      .wb_done_vld(wb_done_vld), .wb_done_rob_id(wb_done_rob_id), .wb_done_txnid(wb_done_txnid),
      .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [AW-1:0] addr; logic [IDW-1:0] id; logic [7:0] len; int cyc; } aw_rec_t;
   typedef struct { logic [DW-1:0] data; logic last; int cyc; } w_rec_t;
   typedef struct { logic [RW-1:0] rob; logic [TW-1:0] txn; int cyc; } done_rec_t;

   aw_rec_t   aw_log[$];
   w_rec_t    w_log[$];
   done_rec_t done_log[$];

   int n_checks = 0;
   int n_fail   = 0;
   int acc_cyc  = 0;
   int first_cyc = 0;
   int acc_count = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if (aw_vld && aw_rdy) aw_log.push_back('{addr: aw_addr, id: aw_id, len: aw_len, cyc: cyc});
         if (w_vld && w_rdy)   w_log.push_back('{data: w_data, last: w_last, cyc: cyc});
         if (wb_done_vld)      done_log.push_back('{rob: wb_done_rob_id, txn: wb_done_txnid, cyc: cyc});
      end
   end

   // ---------------------------------------------------------------- helpers
   function automatic logic [DW-1:0] mk_data(input int tag, input int beat);
      logic [31:0] w;
      w = 32'(tag * 16 + beat) ^ 32'hA5A5_0000;
      return {(DW/32){w}};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      aw_log.delete();
      w_log.delete();
      done_log.delete();
   endtask

   task automatic send_beat(input logic [AW-1:0] a, input logic [RW-1:0] r,
                            input logic [TW-1:0] t, input logic [DW-1:0] d, input logic l);
      int n;
      n = 0;
      ev_vld = 1'b1; ev_addr = a; ev_rob_id = r; ev_txnid = t; ev_data = d; ev_last = l;
      @(negedge clk);
      while (!ev_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!ev_rdy) begin
         n_checks++; n_fail++;
         $display("FAIL ev_accept_timeout: ev_rdy=%0b after %0d cycles, required 1", ev_rdy, n);
      end
      step();
      acc_cyc = cyc;
      acc_count++;
      ev_vld = 1'b0;
   endtask

   task automatic send_line(input logic [AW-1:0] a, input logic [RW-1:0] r,
                            input logic [TW-1:0] t, input int tag, input int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         send_beat(a, r, t, mk_data(tag, b), (b == nbeats - 1));
         if (b == 0) first_cyc = acc_cyc;
      end
   endtask

   task automatic pulse_b(input logic [IDW-1:0] id, output int bc);
      b_vld = 1'b1;
      b_id  = id;
      bc    = cyc;
      step();
      b_vld = 1'b0;
   endtask

   task automatic wait_logs(input int n_aw, input int n_w, input int n_done, input int budget);
      int n;
      n = 0;
      while ((aw_log.size() < n_aw || w_log.size() < n_w || done_log.size() < n_done) && n < budget) begin
         step();
         n++;
      end
      if (aw_log.size() < n_aw || w_log.size() < n_w || done_log.size() < n_done) begin
         n_checks++; n_fail++;
         $display("FAIL wait_logs: aw=%0d w=%0d done=%0d, required aw=%0d w=%0d done=%0d",
                  aw_log.size(), w_log.size(), done_log.size(), n_aw, n_w, n_done);
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({ev_rdy, aw_vld, w_vld, w_last, wb_done_vld, err_sticky, aw_id, wb_done_rob_id, wb_done_txnid} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: rdy=%0b aw_vld=%0b w_vld=%0b w_last=%0b done=%0b err=%b aw_id=%0d rob=%0d txn=%0h, required all 0",
                  ev_rdy, aw_vld, w_vld, w_last, wb_done_vld, err_sticky, aw_id, wb_done_rob_id, wb_done_txnid);
      end
      n_checks++;
      if (aw_addr !== '0 || w_data !== '0) begin
         n_fail++;
         $display("FAIL reset_payload: aw_addr=%0h w_data_lsw=%0h, required 0", aw_addr, w_data[31:0]);
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (ev_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_rdy: ev_rdy=%0b, required 1", ev_rdy);
      end
   endtask

   task automatic test_single_line();
      int bc;
      clear_logs();
      aw_rdy = 1'b1;
      w_rdy  = 1'b1;
      send_line(40'h1000, 6'd5, 8'h21, 1, 4);
      wait_logs(1, 4, 0, 20);
      n_checks++;
      if (aw_log[0].addr !== 40'h1000 || aw_log[0].id !== 3'd0 || aw_log[0].len !== 8'd3) begin
         n_fail++;
         $display("FAIL single_aw: addr=%0h id=%0d len=%0d, required 1000 0 3", aw_log[0].addr, aw_log[0].id, aw_log[0].len);
      end
      n_checks++;
      if (aw_log[0].cyc !== first_cyc || w_log[0].cyc !== first_cyc) begin
         n_fail++;
         $display("FAIL single_latency: aw_cyc=%0d w_cyc=%0d, required %0d", aw_log[0].cyc, w_log[0].cyc, first_cyc);
      end
      for (int b = 0; b < 4; b++) begin
         n_checks++;
         if (w_log[b].data !== mk_data(1, b) || w_log[b].last !== (b == 3)) begin
            n_fail++;
            $display("FAIL single_w%0d: data_lsw=%0h last=%0b, required %0h %0b",
                     b, w_log[b].data[31:0], w_log[b].last, mk_data(1, b) & 32'hFFFF_FFFF, (b == 3));
         end
      end
      repeat (3) step();
      pulse_b(3'd0, bc);
      wait_logs(1, 4, 1, 10);
      repeat (3) step();
      n_checks++;
      if (done_log.size() !== 1 || done_log[0].rob !== 6'd5 || done_log[0].txn !== 8'h21 || done_log[0].cyc !== bc + 1) begin
         n_fail++;
         $display("FAIL single_done: count=%0d rob=%0d txn=%0h cyc=%0d, required 1 5 21 %0d",
                  done_log.size(), done_log[0].rob, done_log[0].txn, done_log[0].cyc, bc + 1);
      end
   endtask

   task automatic test_back_to_back();
      int bc;
      int hi;
      logic [RW-1:0] exp_rob;
      clear_logs();
      for (int l = 0; l < 8; l++)
         send_line(40'h2_0000 + 40'(l * 64), 6'(10 + l), 8'(8'h40 + l), 100 + l, 4);
      wait_logs(8, 32, 0, 20);
      for (int l = 0; l < 8; l++) begin
         n_checks++;
         if (aw_log[l].id !== 3'(l) || aw_log[l].addr !== 40'h2_0000 + 40'(l * 64)) begin
            n_fail++;
            $display("FAIL b2b_aw%0d: id=%0d addr=%0h, required %0d %0h", l, aw_log[l].id, aw_log[l].addr, l, 40'h2_0000 + 40'(l * 64));
         end
      end
      // Ninth line: no slot free, so ev_rdy must stay low.
      ev_vld = 1'b1; ev_addr = 40'h2_0200; ev_rob_id = 6'd18; ev_txnid = 8'h48;
      ev_data = mk_data(108, 0); ev_last = 1'b0;
      hi = 0;
      repeat (5) begin
         @(negedge clk);
         if (ev_rdy) hi++;
      end
      n_checks++;
      if (hi !== 0) begin
         n_fail++;
         $display("FAIL b2b_full_rdy: ev_rdy high %0d cycles, required 0", hi);
      end
      step();
      pulse_b(3'd3, bc);
      send_line(40'h2_0200, 6'd18, 8'h48, 108, 4);
      wait_logs(9, 36, 1, 30);
      n_checks++;
      if (aw_log[8].id !== 3'd3 || aw_log[8].addr !== 40'h2_0200) begin
         n_fail++;
         $display("FAIL b2b_ninth_aw: id=%0d addr=%0h, required 3 20200", aw_log[8].id, aw_log[8].addr);
      end
      n_checks++;
      if (done_log[0].rob !== 6'd13 || done_log[0].txn !== 8'h43) begin
         n_fail++;
         $display("FAIL b2b_done3: rob=%0d txn=%0h, required 13 43", done_log[0].rob, done_log[0].txn);
      end
      for (int k = 0; k < 8; k++) pulse_b(3'(k), bc);
      wait_logs(9, 36, 9, 20);
      for (int k = 0; k < 8; k++) begin
         exp_rob = (k == 3) ? 6'd18 : 6'(10 + k);
         n_checks++;
         if (done_log[1 + k].rob !== exp_rob) begin
            n_fail++;
            $display("FAIL b2b_release%0d: rob=%0d, required %0d", k, done_log[1 + k].rob, exp_rob);
         end
      end
   endtask

   task automatic test_w_backpressure();
      clear_logs();
      aw_rdy = 1'b1;
      w_rdy  = 1'b0;
      acc_count = 0;
      fork
         begin
            for (int l = 0; l < 3; l++)
               send_line(40'h3000 + 40'(l * 64), 6'(20 + l), 8'(8'h60 + l), 20 + l, 4);
         end
         begin
            repeat (20) @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (acc_count !== 8 || ev_rdy !== 1'b0 || w_log.size() !== 0) begin
               n_fail++;
               $display("FAIL wbp_stall: accepted=%0d ev_rdy=%0b w_out=%0d, required 8 0 0", acc_count, ev_rdy, w_log.size());
            end
            w_rdy = 1'b1;
         end
      join
      wait_logs(3, 12, 0, 40);
      for (int i = 0; i < 12; i++) begin
         n_checks++;
         if (w_log[i].data !== mk_data(20 + i / 4, i % 4) || w_log[i].last !== (i % 4 == 3)) begin
            n_fail++;
            $display("FAIL wbp_order%0d: data_lsw=%0h last=%0b, required %0h %0b",
                     i, w_log[i].data[31:0], w_log[i].last, mk_data(20 + i / 4, i % 4) & 32'hFFFF_FFFF, (i % 4 == 3));
         end
      end
      n_checks++;
      if (aw_log[0].id !== 3'd0 || aw_log[1].id !== 3'd1 || aw_log[2].id !== 3'd2) begin
         n_fail++;
         $display("FAIL wbp_aw_ids: %0d %0d %0d, required 0 1 2", aw_log[0].id, aw_log[1].id, aw_log[2].id);
      end
   endtask

   task automatic test_out_of_order();
      int bc;
      logic [IDW-1:0] ids [3];
      logic [RW-1:0]  robs [3];
      ids  = '{3'd2, 3'd0, 3'd1};
      robs = '{6'd22, 6'd20, 6'd21};
      clear_logs();
      for (int k = 0; k < 3; k++) pulse_b(ids[k], bc);
      wait_logs(0, 0, 3, 10);
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (done_log[k].rob !== robs[k] || done_log[k].txn !== 8'(8'h60 + ids[k])) begin
            n_fail++;
            $display("FAIL ooo_done%0d: rob=%0d txn=%0h, required %0d %0h",
                     k, done_log[k].rob, done_log[k].txn, robs[k], 8'(8'h60 + ids[k]));
         end
      end
      pulse_b(3'd6, bc);
      repeat (3) step();
      n_checks++;
      if (done_log.size() !== 3 || err_sticky !== 2'b10) begin
         n_fail++;
         $display("FAIL ooo_free_resp: done_count=%0d err=%b, required 3 10", done_log.size(), err_sticky);
      end
   endtask

   task automatic test_beat_err();
      int bc;
      logic [5:0] last_pat;
      clear_logs();
      send_line(40'h4000, 6'd30, 8'h70, 30, 2);
      step();
      n_checks++;
      if (err_sticky !== 2'b11) begin
         n_fail++;
         $display("FAIL berr_flag: err=%b, required 11", err_sticky);
      end
      send_line(40'h4040, 6'd31, 8'h71, 31, 4);
      wait_logs(2, 6, 0, 20);
      last_pat = 6'b100010;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (w_log[i].last !== last_pat[i] ||
             w_log[i].data !== ((i < 2) ? mk_data(30, i) : mk_data(31, i - 2))) begin
            n_fail++;
            $display("FAIL berr_w%0d: last=%0b data_lsw=%0h, required last %0b", i, w_log[i].last, w_log[i].data[31:0], last_pat[i]);
         end
      end
      n_checks++;
      if (aw_log[0].id !== 3'd0 || aw_log[1].id !== 3'd1 || aw_log[1].addr !== 40'h4040) begin
         n_fail++;
         $display("FAIL berr_aw: ids %0d %0d addr=%0h, required 0 1 4040", aw_log[0].id, aw_log[1].id, aw_log[1].addr);
      end
      pulse_b(3'd0, bc);
      pulse_b(3'd1, bc);
      wait_logs(2, 6, 2, 10);
      n_checks++;
      if (done_log[0].rob !== 6'd30 || done_log[1].rob !== 6'd31) begin
         n_fail++;
         $display("FAIL berr_done: rob %0d %0d, required 30 31", done_log[0].rob, done_log[1].rob);
      end
   endtask

   task automatic test_reset_mid();
      int bc;
      clear_logs();
      aw_rdy = 1'b0;
      w_rdy  = 1'b0;
      send_beat(40'h5000, 6'd40, 8'h80, mk_data(40, 0), 1'b0);
      send_beat(40'h5000, 6'd40, 8'h80, mk_data(40, 1), 1'b0);
      n_checks++;
      if (aw_vld !== 1'b1 || w_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_pending: aw_vld=%0b w_vld=%0b, required 1 1", aw_vld, w_vld);
      end
      ev_vld = 1'b1; ev_data = mk_data(40, 2);
      #2;
      rst = 1'b1;
      ev_vld = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({ev_rdy, aw_vld, w_vld, w_last, wb_done_vld, err_sticky, aw_id, wb_done_rob_id, wb_done_txnid} !== '0 ||
          aw_addr !== '0 || w_data !== '0) begin
         n_fail++;
         $display("FAIL rmid_outputs: rdy=%0b aw_vld=%0b w_vld=%0b done=%0b err=%b aw_addr=%0h, required all 0",
                  ev_rdy, aw_vld, w_vld, wb_done_vld, err_sticky, aw_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      step();
      clear_logs();
      aw_rdy = 1'b1;
      w_rdy  = 1'b1;
      repeat (5) step();
      n_checks++;
      if (aw_log.size() !== 0 || w_log.size() !== 0 || done_log.size() !== 0) begin
         n_fail++;
         $display("FAIL rmid_stale: aw=%0d w=%0d done=%0d, required 0 0 0", aw_log.size(), w_log.size(), done_log.size());
      end
      send_line(40'h5100, 6'd41, 8'h81, 41, 4);
      wait_logs(1, 4, 0, 20);
      n_checks++;
      if (aw_log[0].id !== 3'd0 || aw_log[0].addr !== 40'h5100 || w_log[0].data !== mk_data(41, 0) ||
          w_log[3].data !== mk_data(41, 3) || w_log[3].last !== 1'b1 || err_sticky !== 2'b00) begin
         n_fail++;
         $display("FAIL rmid_next_line: id=%0d addr=%0h w0_lsw=%0h w3_last=%0b err=%b, required 0 5100 data(41,0) 1 00",
                  aw_log[0].id, aw_log[0].addr, w_log[0].data[31:0], w_log[3].last, err_sticky);
      end
      pulse_b(3'd0, bc);
      wait_logs(1, 4, 1, 10);
      n_checks++;
      if (done_log.size() !== 1 || done_log[0].rob !== 6'd41 || done_log[0].txn !== 8'h81) begin
         n_fail++;
         $display("FAIL rmid_done: count=%0d rob=%0d txn=%0h, required 1 41 81", done_log.size(), done_log[0].rob, done_log[0].txn);
      end
   endtask

   initial begin
      test_reset();
      test_single_line();
      test_back_to_back();
      test_w_backpressure();
      test_out_of_order();
      test_beat_err();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
